// File: rtl/rect_painter.sv
// Rectangle rasteriser that feeds the VGA pixel-write port one pixel per cycle.
// Region is clipped to the screen. Supports solid or outline fill and arbiter stalls.
module rect_painter #(
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOR_W  = 3,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic [X_W-1:0]     x0,
   input  logic [Y_W-1:0]     y0,
   input  logic [X_W-1:0]     w,
   input  logic [Y_W-1:0]     h,
   input  logic [COLOR_W-1:0] color_in,
   input  logic               outline,
   input  logic               hold,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [COLOR_W-1:0] color,
   output logic               vga_en,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_FINISH} state_t;

   localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

   state_t             r_state;
   logic [X_W-1:0]     r_x0;
   logic [Y_W-1:0]     r_y0;
   logic [X_W-1:0]     r_w;
   logic [Y_W-1:0]     r_h;
   logic [COLOR_W-1:0] r_color;
   logic               r_outline;
   logic [X_W-1:0]     r_xEnd;
   logic [Y_W-1:0]     r_yEnd;

   logic [X_W:0] w_xAvail;
   logic [Y_W:0] w_yAvail;
   logic [X_W:0] w_ew;
   logic [Y_W:0] w_eh;
   logic         w_rowEnd;
   logic         w_lastPix;
   logic         w_fullRow;

   // Clip one bit wider than the coordinates so origin+size can never wrap.
   assign w_xAvail = SCR_W - {1'b0, r_x0};
   assign w_yAvail = SCR_H - {1'b0, r_y0};
   assign w_ew = ({1'b0, r_x0} >= SCR_W) ? '0 :
                 (({1'b0, r_w} < w_xAvail) ? {1'b0, r_w} : w_xAvail);
   assign w_eh = ({1'b0, r_y0} >= SCR_H) ? '0 :
                 (({1'b0, r_h} < w_yAvail) ? {1'b0, r_h} : w_yAvail);

   assign w_rowEnd  = (x == r_xEnd);
   assign w_lastPix = w_rowEnd && (y == r_yEnd);
   assign w_fullRow = !r_outline || (y == r_y0) || (y == r_yEnd);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_x0      <= '0;
         r_y0      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_color   <= '0;
         r_outline <= 1'b0;
         r_xEnd    <= '0;
         r_yEnd    <= '0;
         x         <= '0;
         y         <= '0;
         color     <= '0;
         vga_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done   <= 1'b0;
               vga_en <= 1'b0;
               busy   <= 1'b0;
               if (start) begin
                  r_x0      <= x0;
                  r_y0      <= y0;
                  r_w       <= w;
                  r_h       <= h;
                  r_color   <= color_in;
                  r_outline <= outline;
                  busy      <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_ew == '0 || w_eh == '0) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_xEnd  <= X_W'({1'b0, r_x0} + w_ew - 1'b1);
                  r_yEnd  <= Y_W'({1'b0, r_y0} + w_eh - 1'b1);
                  x       <= r_x0;
                  y       <= r_y0;
                  color   <= r_color;
                  vga_en  <= 1'b1;
                  r_state <= S_DRAW;
               end
            end
            S_DRAW: begin
               // Interior outline rows hop straight from the left edge to the right edge.
               if (!hold) begin
                  if (w_lastPix) begin
                     vga_en  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     r_state <= S_FINISH;
                  end else if (w_rowEnd) begin
                     x <= r_x0;
                     y <= y + 1'b1;
                  end else if (w_fullRow) begin
                     x <= x + 1'b1;
                  end else begin
                     x <= r_xEnd;
                  end
               end
            end
            S_FINISH: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               vga_en  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
